// File: rtl/router_input_fifo_if.sv
// router_input_fifo_if
//   Bundles the write-side (upstream link), read-side (allocator/crossbar)
//   and status signals of one router input buffer.
//   Ports/signals:
//     valid_in, flit_in      upstream flit and its valid strobe
//     read_en                downstream pop request
//     credit_out             one-cycle credit return pulse to upstream
//     empty, full            occupancy status (empty feeds LBDR)
//     flit_out, flit_id,
//     dst_addr, src_addr     head flit and its decoded fields
//     overflow_err,
//     frame_err              sticky error flags
//   Modports:
//     slave  - the FIFO itself
//     master - whatever drives the FIFO (router glue or testbench)
interface router_input_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid_in;
  logic [DATA_WIDTH-1:0] flit_in;
  logic                  read_en;
  logic                  credit_out;
  logic                  empty;
  logic                  full;
  logic [DATA_WIDTH-1:0] flit_out;
  logic [2:0]            flit_id;
  logic [3:0]            dst_addr;
  logic [3:0]            src_addr;
  logic                  overflow_err;
  logic                  frame_err;

  modport slave (
    input  valid_in, flit_in, read_en,
    output credit_out, empty, full, flit_out, flit_id, dst_addr, src_addr,
           overflow_err, frame_err
  );

  modport master (
    output valid_in, flit_in, read_en,
    input  credit_out, empty, full, flit_out, flit_id, dst_addr, src_addr,
           overflow_err, frame_err
  );
endinterface

// File: rtl/router_input_fifo.sv
// router_input_fifo
//   Input buffer for one router port. Stores flits arriving under
//   credit-based flow control in a circular FIFO, exposes the head flit with
//   decoded flit_id / dst_addr / src_addr, returns one credit per popped
//   flit, and checks HEADER/BODY/TAIL ordering on the write side.
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - asynchronous active-high reset
//     bus  - router_input_fifo_if.slave (handshake, head flit, status, errors)
//   Parameters:
//     DATA_WIDTH - flit width in bits (flit_id lives in the top 3 bits)
//     DEPTH      - number of slots, power of two, >= 2
module router_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input logic               clk,
  input logic               rst,
  router_input_fifo_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] ID_HEADER = 3'b001;
  localparam logic [2:0] ID_BODY   = 3'b010;
  localparam logic [2:0] ID_TAIL   = 3'b100;

  typedef enum logic {
    ST_IDLE,
    ST_IN_PKT
  } frame_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             credit_reg;
  logic             overflow_err_reg;
  logic             frame_err_reg;
  frame_state_t     state_reg;
  frame_state_t     state_next;

  logic       empty;
  logic       full;
  logic       rd_accept;
  logic       wr_accept;
  logic       frame_bad;
  logic [2:0] in_id;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign in_id = bus.flit_in[DATA_WIDTH-1 -: 3];

  // A pop only counts when there is something to pop; read_en on an empty
  // buffer is silently ignored.
  assign rd_accept = bus.read_en && !empty;

  // Framing FSM: only flits that reach a non-full buffer are examined. A
  // flit arriving while full is an overflow and never touches the framing
  // state, even if a pop frees a slot on the same edge.
  always_comb begin
    state_next = state_reg;
    wr_accept  = 1'b0;
    frame_bad  = 1'b0;
    if (bus.valid_in && !full) begin
      unique case (state_reg)
        ST_IDLE: begin
          if (in_id == ID_HEADER) begin
            wr_accept  = 1'b1;
            state_next = ST_IN_PKT;
          end else begin
            frame_bad = 1'b1;
          end
        end
        ST_IN_PKT: begin
          if (in_id == ID_BODY) begin
            wr_accept = 1'b1;
          end else if (in_id == ID_TAIL) begin
            wr_accept  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            frame_bad = 1'b1;
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= bus.flit_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      count_reg        <= '0;
      credit_reg       <= 1'b0;
      overflow_err_reg <= 1'b0;
      frame_err_reg    <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      // Simultaneous accepted push and pop leave the occupancy unchanged.
      unique case ({wr_accept, rd_accept})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
      credit_reg <= rd_accept;
      if (bus.valid_in && full) begin
        overflow_err_reg <= 1'b1;
      end
      if (frame_bad) begin
        frame_err_reg <= 1'b1;
      end
    end
  end

  // Head flit is read combinationally so a flit written at edge N is
  // visible to LBDR before edge N+1.
  assign bus.flit_out     = mem[rd_ptr_reg];
  assign bus.flit_id      = bus.flit_out[DATA_WIDTH-1 -: 3];
  assign bus.dst_addr     = bus.flit_out[3:0];
  assign bus.src_addr     = bus.flit_out[7:4];
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.credit_out   = credit_reg;
  assign bus.overflow_err = overflow_err_reg;
  assign bus.frame_err    = frame_err_reg;

endmodule

// File: tb/tb_router_input_fifo.sv
module tb_router_input_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  localparam logic [2:0] HDR  = 3'b001;
  localparam logic [2:0] BODY = 3'b010;
  localparam logic [2:0] TAIL = 3'b100;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  router_input_fifo_if #(.DATA_WIDTH(DW)) bus ();

  router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the buffer is a queue of stored flits, packet state is
  // a single "inside a packet" bit.
  logic [DW-1:0] q[$];
  bit            m_in_pkt;
  bit            m_ovf;
  bit            m_frm;
  bit            m_credit;

  function automatic logic [DW-1:0] mkflit(input logic [2:0] id,
                                           input logic [3:0] src,
                                           input logic [3:0] dst);
    logic [20:0] mid;
    mid = 21'($urandom);
    return {id, mid, src, dst};
  endfunction

  task automatic model_clear();
    q.delete();
    m_in_pkt = 0;
    m_ovf    = 0;
    m_frm    = 0;
    m_credit = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.valid_in = 1'b0;
    bus.flit_in  = '0;
    bus.read_en  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  // Drive one cycle and advance the model; returns at posedge+1.
  task automatic drive(input bit v, input logic [DW-1:0] f, input bit r);
    bit            was_full;
    bit            rd;
    bit            wr;
    logic [2:0]    id;
    @(negedge clk);
    bus.valid_in = v;
    bus.flit_in  = f;
    bus.read_en  = r;
    @(posedge clk);
    was_full = (q.size() == DEPTH);
    rd = r && (q.size() != 0);
    wr = 0;
    id = f[DW-1 -: 3];
    if (v) begin
      if (was_full) begin
        m_ovf = 1;
      end else if (!m_in_pkt) begin
        if (id == HDR) begin wr = 1; m_in_pkt = 1; end
        else m_frm = 1;
      end else begin
        if (id == BODY) wr = 1;
        else if (id == TAIL) begin wr = 1; m_in_pkt = 0; end
        else m_frm = 1;
      end
    end
    if (rd) void'(q.pop_front());
    if (wr) q.push_back(f);
    m_credit = rd;
    #1;
    bus.valid_in = 1'b0;
    bus.read_en  = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.empty); end
    total++; if (bus.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.full); end
    total++; if (bus.credit_out !== 1'b0) begin bad++; $display("FAIL reset_credit got=%b exp=0", bus.credit_out); end
    total++; if ({bus.overflow_err, bus.frame_err} !== 2'b00) begin bad++; $display("FAIL reset_errs got=%b%b exp=00", bus.overflow_err, bus.frame_err); end
    $display("test_reset: empty=%b full=%b credit=%b", bus.empty, bus.full, bus.credit_out);
  endtask

  task automatic test_header_visible();
    logic [DW-1:0] h;
    do_reset();
    h = mkflit(HDR, 4'h5, 4'h9);
    drive(1, h, 0);
    total++; if (bus.empty !== 1'b0) begin bad++; $display("FAIL hdr_empty got=%b exp=0", bus.empty); end
    total++; if (bus.flit_id !== HDR) begin bad++; $display("FAIL hdr_id got=%b exp=%b", bus.flit_id, HDR); end
    total++; if (bus.dst_addr !== 4'h9) begin bad++; $display("FAIL hdr_dst got=%h exp=9", bus.dst_addr); end
    total++; if (bus.src_addr !== 4'h5) begin bad++; $display("FAIL hdr_src got=%h exp=5", bus.src_addr); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL hdr_frame_err got=%b exp=0", bus.frame_err); end
    $display("test_header_visible: flit=%h id=%b dst=%h src=%h", bus.flit_out, bus.flit_id, bus.dst_addr, bus.src_addr);
  endtask

  task automatic test_fill_overflow();
    logic [DW-1:0] pkt [4];
    logic [DW-1:0] exp_f;
    do_reset();
    pkt[0] = mkflit(HDR, 4'h1, 4'h2);
    pkt[1] = mkflit(BODY, 4'h3, 4'h4);
    pkt[2] = mkflit(BODY, 4'h5, 4'h6);
    pkt[3] = mkflit(TAIL, 4'h7, 4'h8);
    for (int i = 0; i < 4; i++) drive(1, pkt[i], 0);
    total++; if (bus.full !== 1'b1) begin bad++; $display("FAIL fill_full got=%b exp=1", bus.full); end
    drive(1, mkflit(HDR, 4'hA, 4'hB), 0);
    total++; if (bus.overflow_err !== 1'b1) begin bad++; $display("FAIL fill_overflow got=%b exp=1", bus.overflow_err); end
    total++; if (bus.frame_err !== 1'b0) begin bad++; $display("FAIL fill_frame_err got=%b exp=0", bus.frame_err); end
    for (int i = 0; i < 4; i++) begin
      exp_f = q[0];
      total++; if (bus.flit_out !== exp_f || exp_f !== pkt[i]) begin bad++; $display("FAIL fill_order%0d got=%h exp=%h", i, bus.flit_out, pkt[i]); end
      drive(0, '0, 1);
      total++; if (bus.credit_out !== 1'b1) begin bad++; $display("FAIL fill_credit%0d got=%b exp=1", i, bus.credit_out); end
      $display("test_fill_overflow: read %0d flit=%h credit=%b", i, exp_f, bus.credit_out);
    end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL fill_empty_after got=%b exp=1", bus.empty); end
    drive(0, '0, 0);
    total++; if (bus.credit_out !== 1'b0) begin bad++; $display("FAIL fill_credit_end got=%b exp=0", bus.credit_out); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] f;
    logic [DW-1:0] head;
    do_reset();
    drive(1, mkflit(HDR, 4'h2, 4'h3), 0);
    for (int i = 1; i < 20; i++) begin
      f = mkflit((i == 19) ? TAIL : BODY, 4'($urandom), 4'($urandom));
      head = q[0];
      drive(1, f, 1);
      total++; if (bus.credit_out !== 1'b1) begin bad++; $display("FAIL stream_credit%0d got=%b exp=1", i, bus.credit_out); end
      total++; if (bus.empty !== 1'b0 || bus.full !== 1'b0) begin bad++; $display("FAIL stream_count%0d empty=%b full=%b exp 0 0", i, bus.empty, bus.full); end
      total++; if (bus.flit_out !== q[0]) begin bad++; $display("FAIL stream_data%0d got=%h exp=%h", i, bus.flit_out, q[0]); end
      $display("test_stream: cycle %0d popped=%h head=%h", i, head, bus.flit_out);
    end
    drive(0, '0, 1);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL stream_empty_end got=%b exp=1", bus.empty); end
  endtask

  task automatic test_framing();
    logic [DW-1:0] h;
    do_reset();
    h = mkflit(HDR, 4'h6, 4'h7);
    drive(1, mkflit(BODY, 4'h1, 4'h1), 0);
    total++; if (bus.frame_err !== 1'b1) begin bad++; $display("FAIL frame_body_idle got=%b exp=1", bus.frame_err); end
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL frame_body_dropped empty=%b exp=1", bus.empty); end
    drive(1, h, 0);
    drive(1, mkflit(HDR, 4'h8, 4'h9), 0);
    total++; if (bus.flit_out !== h) begin bad++; $display("FAIL frame_head got=%h exp=%h", bus.flit_out, h); end
    drive(0, '0, 1);
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL frame_one_stored empty=%b exp=1", bus.empty); end
    $display("test_framing: frame_err=%b stored=%0d", bus.frame_err, 1);
  endtask

  task automatic test_read_empty();
    logic [DW-1:0] h;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, '0, 1);
      total++; if (bus.credit_out !== 1'b0 || bus.empty !== 1'b1) begin bad++; $display("FAIL rdempty%0d credit=%b empty=%b exp 0 1", i, bus.credit_out, bus.empty); end
      $display("test_read_empty: cycle %0d credit=%b", i, bus.credit_out);
    end
    total++; if (bus.overflow_err !== 1'b0 || bus.frame_err !== 1'b0) begin bad++; $display("FAIL rdempty_errs got=%b%b exp=00", bus.overflow_err, bus.frame_err); end
    h = mkflit(HDR, 4'hC, 4'hD);
    drive(1, h, 0);
    drive(0, '0, 1);
    total++; if (bus.credit_out !== 1'b1 || bus.empty !== 1'b1) begin bad++; $display("FAIL rdempty_after credit=%b empty=%b exp 1 1", bus.credit_out, bus.empty); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, mkflit(HDR, 4'h1, 4'h2), 0);
    drive(1, mkflit(BODY, 4'h3, 4'h4), 0);
    drive(1, mkflit(BODY, 4'h5, 4'h6), 1);
    total++; if (bus.credit_out !== 1'b1) begin bad++; $display("FAIL arst_pre_credit got=%b exp=1", bus.credit_out); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL arst_empty got=%b exp=1", bus.empty); end
    total++; if (bus.credit_out !== 1'b0) begin bad++; $display("FAIL arst_credit got=%b exp=0", bus.credit_out); end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    drive(1, mkflit(BODY, 4'h7, 4'h8), 0);
    total++; if (bus.frame_err !== 1'b1 || bus.empty !== 1'b1) begin bad++; $display("FAIL arst_fsm_idle frame_err=%b empty=%b exp 1 1", bus.frame_err, bus.empty); end
    $display("test_async_reset: frame_err=%b empty=%b", bus.frame_err, bus.empty);
  endtask

  task automatic test_random();
    logic [2:0]    id;
    logic [DW-1:0] f;
    bit            v;
    bit            r;
    int            sel;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 5)       id = HDR;
      else if (sel < 13) id = BODY;
      else if (sel < 18) id = TAIL;
      else               id = 3'($urandom);
      f = mkflit(id, 4'($urandom), 4'($urandom));
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      drive(v, f, r);
      total++;
      if (bus.empty !== (q.size() == 0) || bus.full !== (q.size() == DEPTH) ||
          bus.credit_out !== m_credit || bus.overflow_err !== m_ovf || bus.frame_err !== m_frm) begin
        bad++;
        $display("FAIL rand_status%0d got e=%b f=%b c=%b o=%b fe=%b exp e=%b f=%b c=%b o=%b fe=%b", i,
                 bus.empty, bus.full, bus.credit_out, bus.overflow_err, bus.frame_err,
                 q.size() == 0, q.size() == DEPTH, m_credit, m_ovf, m_frm);
      end
      if (q.size() != 0) begin
        total++;
        if (bus.flit_out !== q[0] || bus.flit_id !== q[0][DW-1 -: 3] ||
            bus.dst_addr !== q[0][3:0] || bus.src_addr !== q[0][7:4]) begin
          bad++;
          $display("FAIL rand_head%0d got=%h exp=%h", i, bus.flit_out, q[0]);
        end
      end
      $display("test_random: cycle %0d v=%b r=%b flit=%h occ=%0d", i, v, r, f, q.size());
    end
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.flit_in  = '0;
    bus.read_en  = 1'b0;
    test_reset();
    test_header_visible();
    test_fill_overflow();
    test_stream();
    test_framing();
    test_read_empty();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
